// File: rtl/a0_trace.sv
// Trace buffer for the cpu a0 result register: every change of a0 is queued
// with a free-running timestamp and drained through a valid/ready port.
module a0_trace #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      a0,
    input  logic                       en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [TS_WIDTH-1:0]        out_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
    logic [TS_WIDTH-1:0]   mem_ts_q   [DEPTH];

    logic [TS_WIDTH-1:0]   ts_q,         ts_d;
    logic [DATA_WIDTH-1:0] prev_a0_q,    prev_a0_d;
    logic [AW-1:0]         wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]         count_q,      count_d;
    logic                  overflow_q,   overflow_d;
    logic [7:0]            drop_count_q, drop_count_d;

    logic chg_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    // Next-state logic: change detect, push/pop arbitration and drop accounting.
    always_comb begin
        chg_s        = en && (a0 != prev_a0_q);
        pop_s        = (count_q != {CW{1'b0}}) && out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push_s       = chg_s && ((count_q < CW'(DEPTH)) || pop_s);
        drop_s       = chg_s && !push_s;

        ts_d         = ts_q + TS_WIDTH'(1);
        prev_a0_d    = a0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q | drop_s;
        drop_count_d = drop_count_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop_s && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q         <= {TS_WIDTH{1'b0}};
            prev_a0_q    <= {DATA_WIDTH{1'b0}};
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            ts_q         <= ts_d;
            prev_a0_q    <= prev_a0_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_data_q[wr_ptr_q] <= a0;
            mem_ts_q[wr_ptr_q]   <= ts_q;
        end
    end

    // Head-of-queue view, forced to zero while empty.
    always_comb begin
        out_valid = (count_q != {CW{1'b0}});
        if (out_valid) begin
            out_data = mem_data_q[rd_ptr_q];
            out_ts   = mem_ts_q[rd_ptr_q];
        end else begin
            out_data = {DATA_WIDTH{1'b0}};
            out_ts   = {TS_WIDTH{1'b0}};
        end
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_a0_trace.sv
// Directed-vector bench for a0_trace: a default-sized instance plus a
// TS_WIDTH=4 instance for timestamp wrap.
module tb_a0_trace;

    logic        clk;
    logic        rst;
    logic [31:0] a0;
    logic        en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_ts;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    logic        w_rst;
    logic [31:0] w_a0;
    logic        w_en;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_data;
    logic [3:0]  w_out_ts;
    logic [2:0]  w_count;
    logic        w_overflow;
    logic [7:0]  w_drop_count;

    int checks;
    int errors;

    logic [31:0] exp_d;
    logic [15:0] exp_t;

    a0_trace dut (
        .clk(clk), .rst(rst), .a0(a0), .en(en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ts(out_ts), .count(count),
        .overflow(overflow), .drop_count(drop_count)
    );

    a0_trace #(.DATA_WIDTH(32), .DEPTH(4), .TS_WIDTH(4)) dut_w (
        .clk(clk), .rst(w_rst), .a0(w_a0), .en(w_en),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .out_ts(w_out_ts), .count(w_count),
        .overflow(w_overflow), .drop_count(w_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After this returns the current cycle has ts=0 and prev_a0=0.
    task automatic do_reset();
        rst = 1'b1;
        a0 = 32'd0;
        en = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 32'd0 || out_ts !== 16'd0) begin errors++; $display("FAIL reset_data got %0d/%0d exp 0/0", out_data, out_ts); end
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_flags got %0b/%0d exp 0/0", overflow, drop_count); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 20; i++) step();
        checks++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL idle got count=%0d valid=%0b ovf=%0b exp 0/0/0", count, out_valid, overflow);
        end
    endtask

    task automatic test_single_change();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        a0 = 32'd5;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got valid=%0b exp 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd5 || out_ts !== 16'd3 || count !== 5'd1) begin
            errors++; $display("FAIL single got v=%0b d=%0d ts=%0d c=%0d exp 1/5/3/1", out_valid, out_data, out_ts, count);
        end
        step();
        checks++; if (out_data !== 32'd5 || out_ts !== 16'd3) begin errors++; $display("FAIL single_hold got %0d/%0d exp 5/3", out_data, out_ts); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || count !== 5'd0 || out_data !== 32'd0) begin
            errors++; $display("FAIL single_pop got v=%0b c=%0d d=%0d exp 0/0/0", out_valid, count, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(); step();
        a0 = 32'd8;
        step();
        a0 = 32'd0;
        step();
        checks++; if (count !== 5'd2 || out_data !== 32'd8 || out_ts !== 16'd2) begin
            errors++; $display("FAIL b2b_first got c=%0d d=%0d ts=%0d exp 2/8/2", count, out_data, out_ts);
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd0 || out_ts !== 16'd3) begin
            errors++; $display("FAIL b2b_second got v=%0b d=%0d ts=%0d exp 1/0/3", out_valid, out_data, out_ts);
        end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int v = 1; v <= 17; v++) begin
            a0 = 32'(v);
            step();
        end
        checks++; if (count !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd1) begin
            errors++; $display("FAIL ovf_state got c=%0d o=%0b dc=%0d exp 16/1/1", count, overflow, drop_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_d = 32'(i + 1);
            exp_t = 16'(i);
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d || out_ts !== exp_t) begin
                errors++; $display("FAIL ovf_drain[%0d] got v=%0b d=%0d ts=%0d exp 1/%0d/%0d", i, out_valid, out_data, out_ts, exp_d, exp_t);
            end
            step();
        end
        checks++; if (out_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_end got v=%0b c=%0d o=%0b exp 0/0/1", out_valid, count, overflow);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int v = 1; v <= 16; v++) begin
            a0 = 32'(v);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a0 = 32'(101 + k);
            exp_d = 32'(k + 1);
            exp_t = 16'(k);
            checks++; if (count !== 5'd16 || out_data !== exp_d || out_ts !== exp_t) begin
                errors++; $display("FAIL fullpop[%0d] got c=%0d d=%0d ts=%0d exp 16/%0d/%0d", k, count, out_data, out_ts, exp_d, exp_t);
            end
            step();
        end
        checks++; if (count !== 5'd16 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL fullpop_state got c=%0d o=%0b dc=%0d exp 16/0/0", count, overflow, drop_count);
        end
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 6) ? 32'(11 + i) : 32'(101 + i - 6);
            exp_t = 16'(10 + i);
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d || out_ts !== exp_t) begin
                errors++; $display("FAIL fullpop_drain[%0d] got d=%0d ts=%0d exp %0d/%0d", i, out_data, out_ts, exp_d, exp_t);
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %0b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int v = 1; v <= 276; v++) begin
            a0 = 32'(v);
            step();
        end
        checks++; if (drop_count !== 8'd255 || count !== 5'd16 || overflow !== 1'b1) begin
            errors++; $display("FAIL saturate got dc=%0d c=%0d o=%0b exp 255/16/1", drop_count, count, overflow);
        end
        checks++; if (out_data !== 32'd1 || out_ts !== 16'd0) begin
            errors++; $display("FAIL saturate_head got %0d/%0d exp 1/0", out_data, out_ts);
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        en = 1'b0;
        a0 = 32'd7;
        step();
        a0 = 32'd9;
        step();
        en = 1'b1;
        step(); step();
        checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL en_gate got c=%0d v=%0b exp 0/0", count, out_valid);
        end
        a0 = 32'd4;
        step(); step();
        checks++; if (count !== 5'd1 || out_data !== 32'd4 || out_ts !== 16'd4) begin
            errors++; $display("FAIL en_capture got c=%0d d=%0d ts=%0d exp 1/4/4", count, out_data, out_ts);
        end
        out_ready = 1'b1;
        step();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL en_drain got %0d exp 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int v = 1; v <= 10; v++) begin
            a0 = 32'(v);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++; if (count !== 5'd6 || out_data !== 32'd5) begin
            errors++; $display("FAIL middrain_pre got c=%0d d=%0d exp 6/5", count, out_data);
        end
        rst = 1'b1;
        a0 = 32'd55;
        step();
        rst = 1'b0;
        a0 = 32'd0;
        checks++; if (count !== 5'd0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_ts !== 16'd0 ||
                      overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL middrain_rst got c=%0d v=%0b d=%0d ts=%0d o=%0b dc=%0d exp all 0",
                               count, out_valid, out_data, out_ts, overflow, drop_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_ts_wrap();
        w_rst = 1'b1;
        w_a0 = 32'd0;
        w_en = 1'b1;
        w_out_ready = 1'b0;
        step();
        w_rst = 1'b0;
        for (int i = 0; i < 15; i++) step();
        w_a0 = 32'd1;
        step();
        w_a0 = 32'd2;
        step();
        checks++; if (w_count !== 3'd2 || w_out_data !== 32'd1 || w_out_ts !== 4'd15) begin
            errors++; $display("FAIL wrap_first got c=%0d d=%0d ts=%0d exp 2/1/15", w_count, w_out_data, w_out_ts);
        end
        w_out_ready = 1'b1;
        step();
        checks++; if (w_out_valid !== 1'b1 || w_out_data !== 32'd2 || w_out_ts !== 4'd0) begin
            errors++; $display("FAIL wrap_second got v=%0b d=%0d ts=%0d exp 1/2/0", w_out_valid, w_out_data, w_out_ts);
        end
        step();
        checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %0b exp 0", w_out_valid); end
        w_out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; a0 = 32'd0; en = 1'b0; out_ready = 1'b0;
        w_rst = 1'b1; w_a0 = 32'd0; w_en = 1'b0; w_out_ready = 1'b0;
        test_reset();
        test_idle();
        test_single_change();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_saturate();
        test_enable_gating();
        test_reset_mid_drain();
        test_ts_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
